// File: rtl/hood_runtime_monitor.sv
// rtl/hood_runtime_monitor.sv - range-hood runtime, countdown, reminder and fault status
//
// Purpose: turns the hood controller's mode outputs into display status.
//   It provides a seconds-remaining countdown for boost (L3) and self-clean,
//   a cumulative extraction run time, a cleaning-due reminder and a
//   state/level consistency fault.
//
// Ports:
//   clk_100Hz      in   1  100 Hz system tick clock
//   reset          in   1  asynchronous, active-high
//   state          in   2  hood class: 00 off, 01 standby, 10 smoking, 11 cleaning
//   smoke_lvl      in   4  0000 off, 1111 standby, 0001 L1, 0010 L2, 0100 L3, 1000 clean
//   clear_runtime  in   1  synchronous clear of run-time accumulator
//   remaining_s    out  8  seconds left in L3/clean, 0 otherwise
//   run_time_s     out 16  cumulative seconds in L1/L2/L3, saturating
//   clean_reminder out  1  high while run_time_s >= REMIND_SECONDS
//   sec_tick       out  1  one-cycle pulse per counted second
//   mode_change    out  1  one-cycle pulse on entry to a new mode
//   fault          out  1  state class disagrees with smoke_lvl class

module hood_runtime_monitor #(
  parameter int TICKS_PER_SEC  = 100,
  parameter int L3_SECONDS     = 60,
  parameter int CLEAN_SECONDS  = 180,
  parameter int REMIND_SECONDS = 36000
) (
  input  logic        clk_100Hz,
  input  logic        reset,
  input  logic [1:0]  state,
  input  logic [3:0]  smoke_lvl,
  input  logic        clear_runtime,
  output logic [7:0]  remaining_s,
  output logic [15:0] run_time_s,
  output logic        clean_reminder,
  output logic        sec_tick,
  output logic        mode_change,
  output logic        fault
);

  typedef enum logic [2:0] {M_OFF, M_STBY, M_RUN, M_L3, M_CLEAN} mode_t;

  localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TW-1:0] TICK_LAST   = TW'(TICKS_PER_SEC - 1);
  localparam logic [7:0]    L3_LOAD     = 8'(L3_SECONDS);
  localparam logic [7:0]    CLEAN_LOAD  = 8'(CLEAN_SECONDS);
  // One extra bit so a threshold above 65535 simply never asserts.
  localparam logic [16:0]   REMIND_THR  = 17'(REMIND_SECONDS);

  logic [3:0]    lvl_q;
  logic [1:0]    state_q;
  mode_t         mode;
  logic          run_sub;      // 0 = L1, 1 = L2; lets L1<->L2 count as a mode change
  logic [TW-1:0] tick_cnt;

  mode_t next_mode;
  logic  next_sub;
  logic  mode_chg;
  logic  running;
  logic  timed;
  logic  [1:0] lvl_class;

  function automatic mode_t decode_mode(input logic [3:0] lvl);
    case (lvl)
      4'b1111: decode_mode = M_STBY;
      4'b0001: decode_mode = M_RUN;
      4'b0010: decode_mode = M_RUN;
      4'b0100: decode_mode = M_L3;
      4'b1000: decode_mode = M_CLEAN;
      default: decode_mode = M_OFF;
    endcase
  endfunction

  function automatic logic [1:0] mode_class(input mode_t m);
    case (m)
      M_STBY:  mode_class = 2'b01;
      M_RUN:   mode_class = 2'b10;
      M_L3:    mode_class = 2'b10;
      M_CLEAN: mode_class = 2'b11;
      default: mode_class = 2'b00;
    endcase
  endfunction

  always_comb begin
    next_mode = decode_mode(lvl_q);
    next_sub  = (lvl_q == 4'b0010);
    lvl_class = mode_class(next_mode);
    mode_chg  = (next_mode != mode) || ((next_mode == M_RUN) && (next_sub != run_sub));
    running   = (mode == M_RUN) || (mode == M_L3) || (mode == M_CLEAN);
    timed     = (mode == M_L3) || (mode == M_CLEAN);
  end

  // Decoded from registered state only, so it is a clean one-cycle pulse.
  assign sec_tick = running && (tick_cnt == TICK_LAST);

  always_ff @(posedge clk_100Hz or posedge reset) begin
    if (reset) begin
      lvl_q          <= 4'b0000;
      state_q        <= 2'b00;
      mode           <= M_OFF;
      run_sub        <= 1'b0;
      tick_cnt       <= '0;
      remaining_s    <= 8'd0;
      run_time_s     <= 16'd0;
      clean_reminder <= 1'b0;
      mode_change    <= 1'b0;
      fault          <= 1'b0;
    end else begin
      lvl_q          <= smoke_lvl;
      state_q        <= state;
      fault          <= (lvl_class != state_q);
      clean_reminder <= ({1'b0, run_time_s} >= REMIND_THR);

      if (mode_chg) begin
        mode        <= next_mode;
        run_sub     <= next_sub;
        mode_change <= 1'b1;
        tick_cnt    <= '0;
        case (next_mode)
          M_L3:    remaining_s <= L3_LOAD;
          M_CLEAN: remaining_s <= CLEAN_LOAD;
          default: remaining_s <= 8'd0;
        endcase
      end else begin
        mode_change <= 1'b0;
        if (!running) begin
          tick_cnt <= '0;
        end else if (tick_cnt == TICK_LAST) begin
          tick_cnt <= '0;
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
        // Countdown stops at 0; the controller decides when the mode ends.
        if (sec_tick && timed && (remaining_s != 8'd0)) begin
          remaining_s <= remaining_s - 8'd1;
        end
      end

      // Accumulator: explicit clear wins over a finished clean, which wins over counting.
      if (clear_runtime) begin
        run_time_s <= 16'd0;
      end else if (sec_tick && (mode == M_CLEAN) && (remaining_s == 8'd1)) begin
        run_time_s <= 16'd0;
      end else if (sec_tick && ((mode == M_RUN) || (mode == M_L3)) && (run_time_s != 16'hFFFF)) begin
        run_time_s <= run_time_s + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_hood_runtime_monitor.sv
// tb/tb_hood_runtime_monitor.sv - scoreboard bench for hood_runtime_monitor

module tb_hood_runtime_monitor;

  logic        clk_100Hz = 1'b0;
  logic        reset;
  logic [1:0]  state;
  logic [3:0]  smoke_lvl;
  logic        clear_runtime;
  logic [7:0]  remaining_s;
  logic [15:0] run_time_s;
  logic        clean_reminder;
  logic        sec_tick;
  logic        mode_change;
  logic        fault;

  hood_runtime_monitor #(
    .TICKS_PER_SEC(100),
    .L3_SECONDS(60),
    .CLEAN_SECONDS(3),
    .REMIND_SECONDS(3)
  ) dut (
    .clk_100Hz(clk_100Hz),
    .reset(reset),
    .state(state),
    .smoke_lvl(smoke_lvl),
    .clear_runtime(clear_runtime),
    .remaining_s(remaining_s),
    .run_time_s(run_time_s),
    .clean_reminder(clean_reminder),
    .sec_tick(sec_tick),
    .mode_change(mode_change),
    .fault(fault)
  );

  always #5 clk_100Hz = ~clk_100Hz;

  typedef enum int {S_REM, S_RUN, S_RMD, S_SEC, S_MC, S_FLT, S_SECN, S_MCN} sig_t;
  typedef struct {
    string tag;
    sig_t  sig;
    int    exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int sec_cnt = 0;
  int mc_cnt = 0;
  int sec_base;
  int mc_base;

  // Pulse monitors, sampled mid-cycle.
  always @(negedge clk_100Hz) begin
    if (sec_tick)    sec_cnt <= sec_cnt + 1;
    if (mode_change) mc_cnt  <= mc_cnt + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int observe(input sig_t s);
    case (s)
      S_REM:   observe = int'(remaining_s);
      S_RUN:   observe = int'(run_time_s);
      S_RMD:   observe = int'(clean_reminder);
      S_SEC:   observe = int'(sec_tick);
      S_MC:    observe = int'(mode_change);
      S_FLT:   observe = int'(fault);
      S_SECN:  observe = sec_cnt;
      default: observe = mc_cnt;
    endcase
  endfunction

  task automatic sb_push(input string label, input sig_t s, input int exp);
    sb_item_t it;
    it.tag = {label, "/", s.name()};
    it.sig = s;
    it.exp = exp;
    sb_q.push_back(it);
  endtask

  task automatic sb_drain();
    sb_item_t it;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      check(it.tag, observe(it.sig), it.exp);
    end
  endtask

  task automatic push_all_zero(input string label);
    sb_push(label, S_REM, 0);
    sb_push(label, S_RUN, 0);
    sb_push(label, S_RMD, 0);
    sb_push(label, S_SEC, 0);
    sb_push(label, S_MC, 0);
    sb_push(label, S_FLT, 0);
  endtask

  // Advance n active edges, then sit 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk_100Hz);
    #1;
  endtask

  initial begin
    reset = 1'b1; state = 2'b00; smoke_lvl = 4'b0000; clear_runtime = 1'b0;
    step(2);
    push_all_zero("reset"); sb_drain();
    reset = 1'b0;
    step(2);

    // Standby entry
    smoke_lvl = 4'b1111; state = 2'b01;
    step(2);
    sb_push("stby", S_MC, 1); sb_push("stby", S_REM, 0); sb_push("stby", S_FLT, 0); sb_drain();
    step(1);
    sb_push("stby_pulse", S_MC, 0); sb_drain();

    // L3 boost countdown
    smoke_lvl = 4'b0100; state = 2'b10;
    step(1);
    sb_push("l3_lat", S_MC, 0); sb_drain();
    step(1);
    sb_push("l3_entry", S_MC, 1); sb_push("l3_entry", S_REM, 60); sb_drain();
    step(99);
    sb_push("l3_tick1", S_SEC, 1); sb_push("l3_tick1", S_REM, 60); sb_drain();
    step(1);
    sb_push("l3_1s", S_REM, 59); sb_push("l3_1s", S_SEC, 0); sb_push("l3_1s", S_RUN, 1); sb_drain();
    step(5899);
    sb_push("l3_last", S_REM, 1); sb_drain();
    step(1);
    sb_push("l3_done", S_REM, 0); sb_push("l3_done", S_RUN, 60); sb_push("l3_done", S_RMD, 1); sb_drain();
    step(100);
    sb_push("l3_hold", S_REM, 0); sb_push("l3_hold", S_RUN, 61); sb_drain();

    // Off, then clear the accumulator
    smoke_lvl = 4'b0000; state = 2'b00;
    step(2);
    sb_push("off", S_MC, 1); sb_push("off", S_REM, 0); sb_push("off", S_RUN, 61); sb_drain();
    clear_runtime = 1'b1;
    step(1);
    clear_runtime = 1'b0;
    sb_push("clr", S_RUN, 0); sb_drain();
    step(1);
    sb_push("clr_rmd", S_RMD, 0); sb_drain();

    // L1 for 3 s, L2 for 2 s
    sec_base = sec_cnt; mc_base = mc_cnt;
    smoke_lvl = 4'b0001; state = 2'b10;
    step(2);
    sb_push("l1_entry", S_MC, 1); sb_drain();
    step(300);
    sb_push("l1_3s", S_RUN, 3); sb_push("l1_3s", S_REM, 0); sb_drain();
    smoke_lvl = 4'b0010;
    step(2);
    sb_push("l2_entry", S_MC, 1); sb_push("l2_entry", S_RUN, 3); sb_drain();
    step(200);
    sb_push("l2_2s", S_RUN, 5); sb_push("l2_2s", S_REM, 0);
    sb_push("l2_2s", S_SECN, sec_base + 5); sb_push("l2_2s", S_MCN, mc_base + 2); sb_drain();

    // Clear coinciding with a counted second
    step(99);
    sb_push("clr_tick", S_SEC, 1); sb_drain();
    clear_runtime = 1'b1;
    step(1);
    clear_runtime = 1'b0;
    sb_push("clr_tick", S_RUN, 0); sb_drain();
    step(100);
    sb_push("after_clr", S_RUN, 1); sb_drain();

    // Reminder threshold
    step(200);
    sb_push("rmd_pre", S_RUN, 3); sb_push("rmd_pre", S_RMD, 0); sb_drain();
    step(1);
    sb_push("rmd_on", S_RMD, 1); sb_drain();

    // Self-clean completes and resets run time
    smoke_lvl = 4'b1000; state = 2'b11;
    step(2);
    sb_push("cln_entry", S_MC, 1); sb_push("cln_entry", S_REM, 3); sb_push("cln_entry", S_RUN, 3); sb_drain();
    step(100);
    sb_push("cln_1s", S_REM, 2); sb_push("cln_1s", S_RUN, 3); sb_drain();
    step(100);
    sb_push("cln_2s", S_REM, 1); sb_push("cln_2s", S_RUN, 3); sb_drain();
    step(99);
    sb_push("cln_tick3", S_SEC, 1); sb_push("cln_tick3", S_REM, 1); sb_drain();
    step(1);
    sb_push("cln_done", S_RUN, 0); sb_push("cln_done", S_REM, 0); sb_push("cln_done", S_RMD, 1); sb_drain();
    step(1);
    sb_push("cln_rmd_off", S_RMD, 0); sb_push("cln_rmd_off", S_FLT, 0); sb_drain();

    // Fault: L3 level while state says standby
    smoke_lvl = 4'b0100; state = 2'b01;
    step(1);
    sb_push("flt_lat", S_FLT, 0); sb_drain();
    step(1);
    sb_push("flt_on", S_FLT, 1); sb_push("flt_on", S_MC, 1); sb_push("flt_on", S_REM, 60); sb_drain();
    step(1800);
    sb_push("mid_l3", S_REM, 42); sb_drain();

    // Asynchronous reset mid-countdown
    reset = 1'b1; smoke_lvl = 4'b1111; state = 2'b01;
    #1;
    push_all_zero("rst_mid"); sb_drain();
    step(2);
    reset = 1'b0;
    step(2);
    sb_push("rst_stby", S_MC, 1); sb_push("rst_stby", S_REM, 0); sb_push("rst_stby", S_FLT, 0); sb_drain();
    step(1);
    sb_push("rst_stby_pulse", S_MC, 0); sb_drain();

    // Invalid level code decodes as off
    smoke_lvl = 4'b0110; state = 2'b10;
    step(2);
    sb_push("inv", S_MC, 1); sb_push("inv", S_FLT, 1); sb_push("inv", S_REM, 0); sb_drain();
    state = 2'b00;
    step(1);
    sb_push("inv_ok_lat", S_FLT, 1); sb_push("inv_ok_lat", S_MC, 0); sb_drain();
    step(1);
    sb_push("inv_ok", S_FLT, 0); sb_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hood_runtime_monitor.md
# hood_runtime_monitor

Consumes the range-hood mode outputs (`state`, `smoke_lvl`) produced by the hood control FSM and turns them into user-facing status: seconds-remaining countdown for the timed modes (level-3 boost and self-clean), cumulative extraction run time, a cleaning-due reminder, and a state/level consistency fault. It sits between the hood controller and the seven-segment/LED display drivers. It runs in the 100 Hz domain and has no handshake back to the controller.

## Interface
Parameters:
- `TICKS_PER_SEC`, 100, `clk_100Hz` cycles per counted second
- `L3_SECONDS`, 60, level-3 boost duration in seconds (≤255)
- `CLEAN_SECONDS`, 180, self-clean duration in seconds (≤255)
- `REMIND_SECONDS`, 36000, run time at which `clean_reminder` asserts

Ports:
- `clk_100Hz`  in  1  100 Hz system tick clock
- `reset`  in  1  asynchronous, active-high; clock `clk_100Hz`
- `state`  in  2  hood class: 00 off, 01 standby, 10 smoking, 11 cleaning
- `smoke_lvl`  in  4  0000 off, 1111 standby, 0001 L1, 0010 L2, 0100 L3, 1000 clean
- `clear_runtime`  in  1  synchronous clear of run-time accumulator (level)
- `remaining_s`  out  8  seconds left in L3/clean; 0 otherwise
- `run_time_s`  out  16  cumulative seconds in L1/L2/L3, saturating
- `clean_reminder`  out  1  high while `run_time_s` ≥ `REMIND_SECONDS`
- `sec_tick`  out  1  one-cycle pulse per counted second in L1/L2/L3/clean
- `mode_change`  out  1  one-cycle pulse on entry to a new mode
- `fault`  out  1  high while `state` disagrees with `smoke_lvl` class

## Operation
- Input stage: `lvl_q`, `state_q` register the inputs every cycle. Any `smoke_lvl` code outside the six listed decodes as OFF.
- FSM states: M_OFF, M_STBY, M_RUN (L1 or L2), M_L3, M_CLEAN. Next state = decode(`lvl_q`) every cycle; any transition between states is allowed, including L1↔L2 (stays M_RUN, still a mode change).
- Mode change (decoded mode differs from previous cycle, L1↔L2 counts): `mode_change`=1 for one cycle, tick counter cleared to 0, `remaining_s` loaded: `L3_SECONDS` for M_L3, `CLEAN_SECONDS` for M_CLEAN, 0 otherwise.
- Tick counter runs 0..`TICKS_PER_SEC`-1 in M_RUN/M_L3/M_CLEAN, wraps to 0; held at 0 in M_OFF/M_STBY. `sec_tick`=1 in the cycle the counter equals `TICKS_PER_SEC`-1.
- Countdown: on each `sec_tick` in M_L3/M_CLEAN, `remaining_s` decrements if nonzero; holds at 0 (no wrap). Controller owns the mode exit; this block only reports.
- Run time: on each `sec_tick` in M_RUN/M_L3, `run_time_s` +1, saturates at 65535.
- Clean completion: `sec_tick` in M_CLEAN with `remaining_s`==1 clears `run_time_s` to 0 on that edge.
- Priority on `run_time_s`: `clear_runtime` > clean completion > increment.
- `clean_reminder` registered from `run_time_s` ≥ `REMIND_SECONDS` (one cycle behind accumulator).
- `fault` registered: 1 when class of `lvl_q` (off/standby/smoking/cleaning) ≠ `state_q`.

## Timing
- Reset: all outputs 0, FSM M_OFF, `lvl_q`=0000, `state_q`=00, tick counter 0; reset mid-countdown abandons it.
- Input change at edge k sampled into `lvl_q`; FSM, `mode_change`, `remaining_s` load at edge k+1 (2-cycle latency).
- First `sec_tick` in a new mode occurs 100 cycles after entry edge; `remaining_s` reaches 0 exactly `L3_SECONDS`×100 = 6000 cycles (L3) after load.
- Exit from M_L3/M_CLEAN sets `remaining_s`=0 at the FSM-update edge.
- `fault` latency 2 cycles from input disagreement; clears 2 cycles after agreement.

## Test plan
- Reset asserted mid-L3 with `remaining_s`=42 -> all outputs 0 immediately; after release with `smoke_lvl`=1111, FSM M_STBY, `remaining_s`=0.
- `smoke_lvl` 1111→0100, `state`=10 -> `mode_change` pulse 2 cycles later, `remaining_s`=60; 59 after 100 cycles; 0 after 6000 cycles, holds; `run_time_s`=60 at that point.
- L1 for 3 s, L2 for 2 s -> `mode_change` at each entry, `run_time_s`=5, `sec_tick` count 5, `remaining_s` stays 0.
- Preload via 36000 s L1 (or `REMIND_SECONDS`=3) -> `clean_reminder`=1; run 1000 clean (`CLEAN_SECONDS`=3) -> `run_time_s`=0 at 3rd `sec_tick`, `clean_reminder` low one cycle later.
- `clear_runtime`=1 coincident with `sec_tick` in L1 -> `run_time_s`=0, no increment; saturate test: 65535 +1 stays 65535.
- `smoke_lvl`=0100 with `state`=01 -> `fault`=1 after 2 cycles; invalid code 0110 -> M_OFF, `fault`=1 unless `state`=00.
